// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input longint clk_hz, input longint baud);
        longint den;
        den = baud * OVERSAMPLE;
        return int'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word fall-through head and a registered overrun pulse.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        overrun_q, overrun_d;
    logic        full, pop, push;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop       = rd_en && !empty;
        // A pop in the same cycle frees the slot the write lands in.
        push      = wr_en && (!full || pop);
        overrun_d = wr_en && full && !pop;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with 16x oversampling, majority-vote data bits and an output FIFO.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 230400,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int TW  = $clog2(DIV + 1);

    rx_state_e   state_q, state_d;
    logic        rxd_meta_q, rxd_meta_d;
    logic        rxd_sync_q, rxd_sync_d;
    logic        rxd_prev_q, rxd_prev_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]  samp_cnt_q, samp_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  vote_q, vote_d;
    logic        frame_err_q, frame_err_d;
    logic        tick, mid, bit_end, fifo_wr, fifo_empty;

    always_comb begin
        rxd_meta_d  = rxd;
        rxd_sync_d  = rxd_meta_q;
        rxd_prev_d  = rxd_sync_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        vote_d      = vote_q;
        frame_err_d = 1'b0;
        fifo_wr     = 1'b0;

        tick       = (tick_cnt_q == TW'(DIV - 1));
        mid        = tick && (samp_cnt_q == 4'd7);
        bit_end    = tick && (samp_cnt_q == 4'd15);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d = tick ? samp_cnt_q + 1'b1 : samp_cnt_q;

        unique case (state_q)
            IDLE: begin
                samp_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (mid && rxd_sync_q) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick && samp_cnt_q == 4'd6) vote_d[0] = rxd_sync_q;
                if (tick && samp_cnt_q == 4'd7) vote_d[1] = rxd_sync_q;
                // Third sample is taken live and voted with the two stored ones.
                if (tick && samp_cnt_q == 4'd8)
                    shift_d = {(vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_sync_q) |
                               (vote_q[1] & rxd_sync_q), shift_q[7:1]};
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (mid) begin
                    if (rxd_sync_q) begin
                        fifo_wr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxd_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            vote_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rxd_meta_q  <= rxd_meta_d;
            rxd_sync_q  <= rxd_sync_d;
            rxd_prev_q  <= rxd_prev_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            vote_q      <= vote_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (shift_q),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .empty   (fifo_empty),
        .overrun (overrun)
    );

    assign m_valid   = !fifo_empty;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
